// File: rtl/output_mem_ctrl_if.sv
// Control bundle between the result de-skew logic and the output
// memory controller: start requests, per-bank enables and addresses.
interface output_mem_ctrl_if #(
  parameter int SYS_COL = 16
) ();
  logic               wr_start;
  logic               rd_start;
  logic [31:0]        num_row;
  logic [SYS_COL-1:0] wr_en;
  logic [7:0]         wr_addr [SYS_COL];
  logic [SYS_COL-1:0] rd_en;
  logic [7:0]         rd_addr [SYS_COL];
  logic               rd_valid;
  logic               wr_done;
  logic               rd_done;
  logic               busy;

  modport master (
    output wr_start, rd_start, num_row,
    input  wr_en, wr_addr, rd_en, rd_addr,
    input  rd_valid, wr_done, rd_done, busy
  );

  modport slave (
    input  wr_start, rd_start, num_row,
    output wr_en, wr_addr, rd_en, rd_addr,
    output rd_valid, wr_done, rd_done, busy
  );
endinterface

// File: rtl/output_mem_ctrl.sv
// Output memory controller: captures a skewed systolic result block
// into per-column banks, then drains it one row per cycle.
module output_mem_ctrl #(
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input logic              clk,
  input logic              rst,
  output_mem_ctrl_if.slave bus
);
  localparam int AW = 8;
  localparam int NW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(DEPTH + SYS_COL) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HOLD,
    DRAIN
  } state_t;

  state_t             state;
  logic [NW-1:0]      n;
  logic [NW-1:0]      n_req;
  logic [CW-1:0]      cnt;
  logic [NW-1:0]      rcnt;
  logic [NW-1:0]      rcnt_nxt;
  logic               cap_last;
  logic               drain_last;
  logic [SYS_COL-1:0] col_en;
  logic [CW-1:0]      col_off [SYS_COL];

  // Bank word width only matters to the memory behind this block.
  logic unused_cfg;
  assign unused_cfg = (DATA_WIDTH > 0);

  always_comb begin
    n_req = bus.num_row[NW-1:0];
    if (bus.num_row > 32'(DEPTH)) n_req = NW'(DEPTH);
  end

  // One extra cycle after the last column's final write before HOLD.
  assign cap_last   = (cnt == CW'(n) + CW'(SYS_COL - 1));
  assign drain_last = (rcnt == n - NW'(1));
  assign rcnt_nxt   = rcnt + NW'(1);

  always_comb begin
    for (int c = 0; c < SYS_COL; c++) begin
      col_off[c] = cnt - CW'(c);
      col_en[c]  = (cnt >= CW'(c)) && (col_off[c] < CW'(n));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      n            <= '0;
      cnt          <= '0;
      rcnt         <= '0;
      bus.wr_en    <= '0;
      bus.rd_en    <= '0;
      bus.rd_valid <= 1'b0;
      bus.wr_done  <= 1'b0;
      bus.rd_done  <= 1'b0;
      bus.busy     <= 1'b0;
      for (int c = 0; c < SYS_COL; c++) begin
        bus.wr_addr[c] <= '0;
        bus.rd_addr[c] <= '0;
      end
    end else begin
      bus.wr_en    <= '0;
      bus.rd_en    <= '0;
      bus.wr_done  <= 1'b0;
      bus.rd_done  <= 1'b0;
      bus.rd_valid <= bus.rd_en[0];
      for (int c = 0; c < SYS_COL; c++) begin
        bus.wr_addr[c] <= '0;
        bus.rd_addr[c] <= '0;
      end
      unique case (state)
        IDLE: begin
          if (bus.wr_start && bus.num_row != '0) begin
            state    <= CAPTURE;
            n        <= n_req;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        CAPTURE: begin
          cnt       <= cnt + CW'(1);
          bus.wr_en <= col_en;
          for (int c = 0; c < SYS_COL; c++) begin
            if (col_en[c]) bus.wr_addr[c] <= col_off[c][AW-1:0];
          end
          if (cap_last) begin
            state       <= HOLD;
            bus.wr_done <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.rd_start) begin
            state     <= DRAIN;
            rcnt      <= '0;
            bus.rd_en <= '1;
          end
        end
        DRAIN: begin
          if (drain_last) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.rd_done <= 1'b1;
          end else begin
            rcnt      <= rcnt_nxt;
            bus.rd_en <= '1;
            for (int c = 0; c < SYS_COL; c++) begin
              bus.rd_addr[c] <= rcnt_nxt[AW-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// Per-column output banks with a one-cycle registered read.
module mem_arr #(
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic [SYS_COL-1:0]    wr_en,
  input  logic [7:0]            wr_addr [SYS_COL],
  input  logic [DATA_WIDTH-1:0] wr_data [SYS_COL],
  input  logic [SYS_COL-1:0]    rd_en,
  input  logic [7:0]            rd_addr [SYS_COL],
  output logic [DATA_WIDTH-1:0] rd_data [SYS_COL]
);
  for (genvar c = 0; c < SYS_COL; c++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q;

    always_ff @(posedge clk) begin
      if (wr_en[c]) mem[wr_addr[c]] <= wr_data[c];
      if (rd_en[c]) q <= mem[rd_addr[c]];
    end

    assign rd_data[c] = q;
  end
endmodule

// File: tb/tb_output_mem_ctrl.sv
// Scoreboard bench: controller plus banks, expected write/read events
// queued at stimulus time and retired as the outputs appear.
module tb_output_mem_ctrl;
  localparam int SYS_COL    = 16;
  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 256;

  typedef struct {
    int cyc;
    int val;
    int blk;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_mem_ctrl_if #(.SYS_COL(SYS_COL)) bus ();

  logic [DATA_WIDTH-1:0] wr_data [SYS_COL];
  logic [DATA_WIDTH-1:0] rd_data [SYS_COL];

  output_mem_ctrl #(
    .SYS_COL(SYS_COL),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  mem_arr #(
    .SYS_COL(SYS_COL),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk(clk),
    .wr_en(bus.wr_en),
    .wr_addr(bus.wr_addr),
    .wr_data(wr_data),
    .rd_en(bus.rd_en),
    .rd_addr(bus.rd_addr),
    .rd_data(rd_data)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int blk      = 0;
  int cur_n    = 0;
  int last_t   = 0;

  ev_t wq [SYS_COL][$];
  ev_t rdq[$];
  ev_t vq[$];
  ev_t wdq[$];
  ev_t ddq[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pat(input int b, input int c,
                                      input logic [7:0] a);
    return {b[3:0], c[3:0], a};
  endfunction

  always_comb begin
    for (int c = 0; c < SYS_COL; c++)
      wr_data[c] = pat(blk, c, bus.wr_addr[c]);
  end

  function automatic int pending();
    int s = wdq.size() + rdq.size() + vq.size() + ddq.size();
    for (int c = 0; c < SYS_COL; c++) s += wq[c].size();
    return s;
  endfunction

  function automatic logic [7:0] addr_or();
    logic [7:0] o = '0;
    for (int c = 0; c < SYS_COL; c++) o |= bus.wr_addr[c] | bus.rd_addr[c];
    return o;
  endfunction

  // Monitor: retire expected events as outputs appear after each edge.
  always @(posedge clk) begin
    ev_t e;
    logic [7:0] idle_or;
    logic [SYS_COL-1:0] ones;
    #1;
    cyc++;
    ones = '1;
    idle_or = '0;
    for (int c = 0; c < SYS_COL; c++) begin
      if (bus.wr_en[c]) begin
        if (wq[c].size() == 0) begin
          check($sformatf("wr_extra[%0d]", c), 1, 0);
        end else begin
          e = wq[c].pop_front();
          check($sformatf("wr_cyc[%0d]", c), cyc, e.cyc);
          check($sformatf("wr_addr[%0d]", c), bus.wr_addr[c], e.val);
        end
      end else begin
        idle_or |= bus.wr_addr[c];
      end
    end
    check("wr_addr_idle", idle_or, 0);
    if (bus.rd_en != '0) begin
      if (rdq.size() == 0) begin
        check("rd_extra", 32'(bus.rd_en), 0);
      end else begin
        e = rdq.pop_front();
        check("rd_cyc", cyc, e.cyc);
        check("rd_en_all", 32'(bus.rd_en), 32'(ones));
        for (int c = 0; c < SYS_COL; c++)
          check($sformatf("rd_addr[%0d]", c), bus.rd_addr[c], e.val);
      end
    end
    if (bus.rd_valid) begin
      if (vq.size() == 0) begin
        check("valid_extra", 1, 0);
      end else begin
        e = vq.pop_front();
        check("valid_cyc", cyc, e.cyc);
        for (int c = 0; c < SYS_COL; c++)
          check($sformatf("rd_data[%0d]", c), rd_data[c],
                pat(e.blk, c, e.val[7:0]));
      end
    end
    if (bus.wr_done) begin
      if (wdq.size() == 0) check("wr_done_extra", 1, 0);
      else begin
        e = wdq.pop_front();
        check("wr_done_cyc", cyc, e.cyc);
      end
    end
    if (bus.rd_done) begin
      if (ddq.size() == 0) check("rd_done_extra", 1, 0);
      else begin
        e = ddq.pop_front();
        check("rd_done_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic start_wr(input int nr, input bit acc);
    ev_t e;
    int n;
    int t;
    bus.num_row  = nr;
    bus.wr_start = 1'b1;
    t = cyc + 1;
    if (acc) begin
      n = (nr > DEPTH) ? DEPTH : nr;
      blk++;
      cur_n  = n;
      last_t = t;
      for (int c = 0; c < SYS_COL; c++) begin
        for (int i = 0; i < n; i++) begin
          e.cyc = t + 1 + c + i;
          e.val = i;
          e.blk = blk;
          wq[c].push_back(e);
        end
      end
      e.cyc = t + n + SYS_COL;
      e.val = 0;
      wdq.push_back(e);
    end
    @(negedge clk);
    bus.wr_start = 1'b0;
  endtask

  task automatic start_rd(input bit acc);
    ev_t e;
    int r;
    bus.rd_start = 1'b1;
    r = cyc + 1;
    if (acc) begin
      e.blk = blk;
      for (int i = 0; i < cur_n; i++) begin
        e.val = i;
        e.cyc = r + i;
        rdq.push_back(e);
        e.cyc = r + 1 + i;
        vq.push_back(e);
      end
      e.cyc = r + cur_n;
      ddq.push_back(e);
    end
    @(negedge clk);
    bus.rd_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (pending() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, pending(), 0);
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_wr_en"}, 32'(bus.wr_en), 0);
    check({pfx, "_rd_en"}, 32'(bus.rd_en), 0);
    check({pfx, "_flags"},
          {bus.rd_valid, bus.wr_done, bus.rd_done, bus.busy}, 0);
    check({pfx, "_addr"}, addr_or(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst          = 1'b1;
    bus.wr_start = 1'b0;
    bus.rd_start = 1'b0;
    bus.num_row  = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");

    // Start on the first edge after reset release; stray requests ignored.
    rst = 1'b0;
    start_wr(8, 1'b1);
    check("busy_capture", bus.busy, 1);
    repeat (3) @(negedge clk);
    start_rd(1'b0);
    wait_idle("capture8", 100);
    check("busy_hold", bus.busy, 1);
    start_wr(5, 1'b0);
    start_rd(1'b1);
    start_wr(4, 1'b0);
    wait_idle("drain8", 100);
    check("busy_after_drain", bus.busy, 0);

    // Zero rows ignored, oversized block clamps to the bank depth.
    start_wr(0, 1'b0);
    check("busy_zero_rows", bus.busy, 0);
    start_wr(300, 1'b1);
    wait_idle("capture256", 400);
    start_rd(1'b1);
    wait_idle("drain256", 400);
    check("busy_after_256", bus.busy, 0);

    // Simultaneous start requests in IDLE begin capture only.
    bus.rd_start = 1'b1;
    start_wr(3, 1'b1);
    bus.rd_start = 1'b0;
    wait_idle("capture3", 100);
    repeat (2) @(negedge clk);
    check("busy_hold3", bus.busy, 1);
    start_rd(1'b1);
    wait_idle("drain3", 100);

    // Abort capture at cnt=5, then a one-row block.
    start_wr(8, 1'b1);
    k = 0;
    while (cyc < last_t + 5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("abort_reach", cyc, last_t + 5);
    rst = 1'b1;
    #1;
    check_quiet("abort");
    for (int c = 0; c < SYS_COL; c++) wq[c].delete();
    wdq.delete();
    rdq.delete();
    vq.delete();
    ddq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_wr(1, 1'b1);
    wait_idle("capture1", 100);
    start_rd(1'b1);
    wait_idle("drain1", 100);
    repeat (3) @(negedge clk);
    check("busy_end", bus.busy, 0);
    check("pending_end", pending(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
